// File: rtl/drive_state_executor_pkg.sv
// Shared encodings for the driving-mode back end: car state, motion codes and
// motion-code helpers used by the executor and its testbench.
package drive_pkg;

    typedef enum logic [1:0] {
        NSTART = 2'b00,
        START  = 2'b01,
        MOVING = 2'b10,
        HOLD   = 2'b11
    } car_state_e;

    typedef enum logic [3:0] {
        NON_MOVING = 4'b0000,
        FWD        = 4'b0001,
        BACK       = 4'b0010,
        LEFT       = 4'b0100,
        RIGHT      = 4'b1000
    } motion_e;

    function automatic logic motion_legal(input logic [3:0] code);
        logic ok;
        case (code)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Forward-ish motions (FWD/LEFT/RIGHT) and BACK are opposite directions of travel.
    function automatic logic is_reversal(input logic [3:0] cur, input logic [3:0] req);
        logic cur_fwd;
        logic req_fwd;
        cur_fwd = (cur == 4'b0001) || (cur == 4'b0100) || (cur == 4'b1000);
        req_fwd = (req == 4'b0001) || (req == 4'b0100) || (req == 4'b1000);
        return (cur_fwd && (req == 4'b0010)) || ((cur == 4'b0010) && req_fwd);
    endfunction

endpackage

// File: rtl/drive_state_executor_if.sv
// Bundle between the active mode's next-state logic / car model and the executor.
// slave = executor side, master = mode logic and car side.
interface drive_state_executor_if;
    logic       pwr_on;
    logic       pwr_off;
    logic       mode_active;
    logic [1:0] next_state;
    logic [3:0] next_moving_st;
    logic       manual_power;
    logic       left_req;
    logic       right_req;
    logic       power;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       move_fwd;
    logic       move_back;
    logic       turn_left;
    logic       turn_right;
    logic       left_light;
    logic       right_light;
    logic       stall_evt;

    modport slave (
        input  pwr_on, pwr_off, mode_active, next_state, next_moving_st,
               manual_power, left_req, right_req,
        output power, state, moving_state, move_fwd, move_back, turn_left,
               turn_right, left_light, right_light, stall_evt
    );

    modport master (
        output pwr_on, pwr_off, mode_active, next_state, next_moving_st,
               manual_power, left_req, right_req,
        input  power, state, moving_state, move_fwd, move_back, turn_left,
               turn_right, left_light, right_light, stall_evt
    );
endinterface

// File: rtl/drive_state_executor_blink_gen.sv
// Turn-signal blink phase generator: counts 0..BLINK_HALF-1, toggles phase on wrap,
// and restarts in the on phase when the light request pattern changes.
module blink_gen #(
    parameter int BLINK_HALF = 50_000_000,
    parameter int CNT_W      = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             phase_r;

    // Blink counter and phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= 1'b1;
        end else if (restart) begin
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= 1'b1;
        end else if (cnt_r == LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    assign phase = phase_r;
endmodule

// File: rtl/drive_state_executor.sv
// Registered back end of the driving-mode next-state interface: power, car state,
// motion with reversal guard, car command decode and turn LEDs (blink via TURN_BLINK_EN).
module drive_state_executor
    import drive_pkg::*;
#(
    parameter int BLINK_HALF = 50_000_000,
    parameter int CNT_W      = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    drive_state_executor_if.slave  bus
);
    logic       power_r;
    logic       power_nxt_s;
    logic       stall_s;
    logic       stall_hit_s;
    logic       stall_hit_r;
    logic       stall_evt_r;
    logic       force_idle_s;
    car_state_e state_r;
    car_state_e state_nxt_s;
    motion_e    moving_r;
    motion_e    moving_nxt_s;
    logic       pend_vld_r;
    logic       pend_vld_nxt_s;
    motion_e    pend_r;
    motion_e    pend_nxt_s;
    logic [1:0] req_s;
    logic [1:0] req_r;
    logic [3:0] car_s;
    logic       phase_s;

    // Power priority: pwr_off, then stall demanded by the mode logic, then pwr_on.
    always_comb begin
        power_nxt_s = power_r;
        stall_s     = bus.mode_active & power_r & ~bus.manual_power;
        stall_hit_s = 1'b0;
        if (bus.pwr_off) begin
            power_nxt_s = 1'b0;
        end else if (stall_s) begin
            power_nxt_s = 1'b0;
            stall_hit_s = 1'b1;
        end else if (bus.pwr_on) begin
            power_nxt_s = 1'b1;
        end else begin
            power_nxt_s = power_r;
        end
    end

    // Idle whenever the car is off, is about to go off this edge, or the mode is inactive.
    assign force_idle_s = ~power_r | ~power_nxt_s | ~bus.mode_active;

    // Car state and motion next-state, including the one-cycle reversal pause.
    always_comb begin
        state_nxt_s    = NSTART;
        moving_nxt_s   = NON_MOVING;
        pend_vld_nxt_s = 1'b0;
        pend_nxt_s     = NON_MOVING;
        if (force_idle_s) begin
            state_nxt_s = NSTART;
        end else if (bus.next_state == 2'b11) begin
            state_nxt_s = state_r;
        end else begin
            state_nxt_s = car_state_e'(bus.next_state);
        end

        if (force_idle_s || (state_nxt_s != MOVING)) begin
            moving_nxt_s = NON_MOVING;
        end else if (pend_vld_r) begin
            // The target captured at the reversal is taken; the request is not re-read.
            moving_nxt_s = pend_r;
        end else if (!motion_legal(bus.next_moving_st)) begin
            moving_nxt_s = NON_MOVING;
        end else if (is_reversal(moving_r, bus.next_moving_st)) begin
            moving_nxt_s   = NON_MOVING;
            pend_vld_nxt_s = 1'b1;
            pend_nxt_s     = motion_e'(bus.next_moving_st);
        end else begin
            moving_nxt_s = motion_e'(bus.next_moving_st);
        end
    end

    assign req_s = {bus.left_req, bus.right_req};

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            power_r     <= 1'b0;
            stall_hit_r <= 1'b0;
            stall_evt_r <= 1'b0;
            state_r     <= NSTART;
            moving_r    <= NON_MOVING;
            pend_vld_r  <= 1'b0;
            pend_r      <= NON_MOVING;
            req_r       <= 2'b00;
        end else begin
            power_r     <= power_nxt_s;
            stall_hit_r <= stall_hit_s;
            stall_evt_r <= stall_hit_r;
            state_r     <= state_nxt_s;
            moving_r    <= moving_nxt_s;
            pend_vld_r  <= pend_vld_nxt_s;
            pend_r      <= pend_nxt_s;
            req_r       <= req_s;
        end
    end

    // One-hot car command decode of the registered motion, silenced when off.
    always_comb begin
        car_s = 4'b0000;
        if (power_r) begin
            case (moving_r)
                FWD:     car_s = 4'b0001;
                BACK:    car_s = 4'b0010;
                LEFT:    car_s = 4'b0100;
                RIGHT:   car_s = 4'b1000;
                default: car_s = 4'b0000;
            endcase
        end else begin
            car_s = 4'b0000;
        end
    end

`ifdef TURN_BLINK_EN
    logic restart_s;
    assign restart_s = (req_s != req_r);

    blink_gen #(
        .BLINK_HALF (BLINK_HALF),
        .CNT_W      (CNT_W)
    ) u_blink_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_s),
        .phase   (phase_s)
    );
`else
    assign phase_s = 1'b1;
`endif

    assign bus.power        = power_r;
    assign bus.state        = state_r;
    assign bus.moving_state = moving_r;
    assign bus.stall_evt    = stall_evt_r;
    assign bus.move_fwd     = car_s[0];
    assign bus.move_back    = car_s[1];
    assign bus.turn_left    = car_s[2];
    assign bus.turn_right   = car_s[3];
    assign bus.left_light   = req_r[1] & power_r & phase_s;
    assign bus.right_light  = req_r[0] & power_r & phase_s;
endmodule
